// File: rtl/led_breather.sv
`default_nettype none
// ============================================================================
// Module   : led_breather
// Purpose  : PWM "breathing" chase across three LEDs. The active channel
//            fades 0 -> 255 -> 0 in STEP increments, one increment every
//            PRESCALE clocks, then hands over to the next channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PRESCALE   sys_clk cycles per brightness tick (>= 2)
//   STEP       brightness change per tick (1..255)
// Ports
//   sys_clk    in   1  system clock
//   sys_rst    in   1  asynchronous active-high reset
//   enable     in   1  run when high, forced idle when low
//   user_led0  out  1  LED channel 0, registered PWM
//   user_led1  out  1  LED channel 1, registered PWM
//   user_led2  out  1  LED channel 2, registered PWM
//   channel    out  2  active channel index (0..2)
//   cycle_done out  1  one-cycle pulse on the 2 -> 0 channel wrap
// ============================================================================
module led_breather #(
  parameter int PRESCALE = 256,
  parameter int STEP     = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       enable,
  output logic       user_led0,
  output logic       user_led1,
  output logic       user_led2,
  output logic [1:0] channel,
  output logic       cycle_done
);

  localparam int              PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [8:0]      STEP_9  = 9'(STEP);
  localparam logic [7:0]      STEP_8  = 8'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } state_t;

  state_t          state_q,      state_d;
  logic [7:0]      pwm_cnt_q,    pwm_cnt_d;
  logic [PS_W-1:0] presc_q,      presc_d;
  logic [7:0]      level_q,      level_d;
  logic [1:0]      channel_q,    channel_d;
  logic [2:0]      led_q,        led_d;
  logic            cycle_done_q, cycle_done_d;

  logic            tick;
  logic [8:0]      rise_sum;
  logic [1:0]      next_channel;
  logic            pwm_on;

  always_comb begin
    tick         = (presc_q == PS_LAST);
    // Nine-bit sum so the saturation test cannot be fooled by wrap-around.
    rise_sum     = {1'b0, level_q} + STEP_9;
    next_channel = (channel_q == 2'd2) ? 2'd0 : channel_q + 2'd1;
    pwm_on       = (pwm_cnt_q < level_q);

    pwm_cnt_d    = pwm_cnt_q + 8'd1;
    state_d      = state_q;
    presc_d      = presc_q;
    level_d      = level_q;
    channel_d    = channel_q;
    cycle_done_d = 1'b0;
    led_d        = 3'b000;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        level_d = 8'd0;
        if (enable) begin
          state_d = ST_RISE;
        end
      end
      ST_RISE: begin
        if (!enable) begin
          // Disable takes priority over any tick in the same cycle.
          state_d = ST_IDLE;
          presc_d = '0;
          level_d = 8'd0;
        end else begin
          presc_d = tick ? '0 : presc_q + PS_W'(1);
          if (tick) begin
            if (rise_sum >= 9'd255) begin
              level_d = 8'd255;
              state_d = ST_FALL;
            end else begin
              level_d = rise_sum[7:0];
            end
          end
        end
      end
      ST_FALL: begin
        if (!enable) begin
          state_d = ST_IDLE;
          presc_d = '0;
          level_d = 8'd0;
        end else begin
          presc_d = tick ? '0 : presc_q + PS_W'(1);
          if (tick) begin
            if (level_q <= STEP_8) begin
              // Hand-over happens on the final fall tick: no dead cycles.
              level_d      = 8'd0;
              channel_d    = next_channel;
              state_d      = ST_RISE;
              cycle_done_d = (channel_q == 2'd2);
            end else begin
              level_d = level_q - STEP_8;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
        level_d = 8'd0;
      end
    endcase

    // LEDs go dark the cycle after enable drops, not one cycle later.
    if ((state_q != ST_IDLE) && enable) begin
      case (channel_q)
        2'd0:    led_d = {2'b00, pwm_on};
        2'd1:    led_d = {1'b0, pwm_on, 1'b0};
        2'd2:    led_d = {pwm_on, 2'b00};
        default: led_d = 3'b000;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      pwm_cnt_q    <= 8'd0;
      presc_q      <= '0;
      level_q      <= 8'd0;
      channel_q    <= 2'd0;
      led_q        <= 3'b000;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_cnt_q    <= pwm_cnt_d;
      presc_q      <= presc_d;
      level_q      <= level_d;
      channel_q    <= channel_d;
      led_q        <= led_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign user_led0  = led_q[0];
  assign user_led1  = led_q[1];
  assign user_led2  = led_q[2];
  assign channel    = channel_q;
  assign cycle_done = cycle_done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_breather.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_breather
// Purpose  : Self-checking bench for led_breather. Three instances:
//            a (PRESCALE=4, STEP=1), b (PRESCALE=256, STEP=100),
//            c (PRESCALE=1024, STEP=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_breather;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       en_a, en_b, en_c;
  logic [2:0] led_a, led_b, led_c;
  logic [1:0] ch_a, ch_b, ch_c;
  logic       done_a, done_b, done_c;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] val;
  } ev_t;

  ev_t exp_q[$];
  ev_t done_q[$];

  led_breather #(.PRESCALE(4), .STEP(1)) dut_a (
    .sys_clk(clk), .sys_rst(rst_a), .enable(en_a),
    .user_led0(led_a[0]), .user_led1(led_a[1]), .user_led2(led_a[2]),
    .channel(ch_a), .cycle_done(done_a));

  led_breather #(.PRESCALE(256), .STEP(100)) dut_b (
    .sys_clk(clk), .sys_rst(rst_b), .enable(en_b),
    .user_led0(led_b[0]), .user_led1(led_b[1]), .user_led2(led_b[2]),
    .channel(ch_b), .cycle_done(done_b));

  led_breather #(.PRESCALE(1024), .STEP(64)) dut_c (
    .sys_clk(clk), .sys_rst(rst_c), .enable(en_c),
    .user_led0(led_c[0]), .user_led1(led_c[1]), .user_led2(led_c[2]),
    .channel(ch_c), .cycle_done(done_c));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after the edge on which dut_a enters RISE.
  task automatic restart_a();
    rst_a = 1'b1;
    en_a  = 1'b0;
    cyc();
    cyc();
    rst_a = 1'b0;
    en_a  = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    total++; if (led_a !== 3'b000) begin bad++; $display("FAIL reset_led_a got %b want 000", led_a); end
    total++; if (ch_a !== 2'd0) begin bad++; $display("FAIL reset_ch_a got %0d want 0", ch_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done_a got %b want 0", done_a); end
    total++; if ({led_b, led_c, ch_b, ch_c, done_b, done_c} !== 12'd0)
      begin bad++; $display("FAIL reset_bc got %h want 000", {led_b, led_c, ch_b, ch_c, done_b, done_c}); end
    rst_a = 1'b0;
    cyc(); cyc(); cyc();
    total++; if ({led_a, ch_a, done_a} !== 6'd0) begin bad++; $display("FAIL idle_outputs got %h want 00", {led_a, ch_a, done_a}); end
    total++; if (dut_a.level_q !== 8'd0) begin bad++; $display("FAIL idle_level got %0d want 0", dut_a.level_q); end
  endtask

  task automatic test_full_chase();
    ev_t        e;
    logic [1:0] prev = 2'd0;
    int         stray = 0;
    exp_q.delete();
    done_q.delete();
    restart_a();
    e.key = 2040; e.val = 1; exp_q.push_back(e);
    e.key = 4080; e.val = 2; exp_q.push_back(e);
    e.key = 6120; e.val = 0; exp_q.push_back(e);
    e.key = 6120; e.val = 0; done_q.push_back(e);
    for (int n = 1; n <= 6130; n++) begin
      cyc();
      // LED register lags channel by one cycle, so mask with the previous one.
      if ((led_a & ~(3'b001 << prev)) != 3'b000) stray++;
      if (ch_a !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL chase_channel unexpected change to %0d at cycle %0d", ch_a, n);
        end else begin
          e = exp_q.pop_front();
          if (n !== int'(e.key) || ch_a !== e.val[1:0]) begin
            bad++; $display("FAIL chase_channel got ch%0d at cycle %0d want ch%0d at cycle %0d", ch_a, n, e.val, e.key);
          end
        end
      end
      if (done_a === 1'b1) begin
        total++;
        if (done_q.size() == 0) begin
          bad++; $display("FAIL chase_done unexpected pulse at cycle %0d", n);
        end else begin
          e = done_q.pop_front();
          if (n !== int'(e.key) || ch_a !== 2'd0) begin
            bad++; $display("FAIL chase_done got cycle %0d ch%0d want cycle %0d ch0", n, ch_a, e.key);
          end
        end
      end
      prev = ch_a;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL chase_missing_channel got %0d pending want 0", exp_q.size()); end
    total++; if (done_q.size() != 0) begin bad++; $display("FAIL chase_missing_done got %0d pending want 0", done_q.size()); end
    total++; if (stray != 0) begin bad++; $display("FAIL chase_inactive_led got %0d cycles want 0", stray); end
  endtask

  task automatic test_async_reset();
    int waited = 0;
    restart_a();
    repeat (3300) cyc();
    total++; if (ch_a !== 2'd1) begin bad++; $display("FAIL arst_pre_channel got %0d want 1", ch_a); end
    total++; if (dut_a.level_q !== 8'd195) begin bad++; $display("FAIL arst_pre_level got %0d want 195", dut_a.level_q); end
    while (led_a[1] !== 1'b1 && waited < 300) begin
      cyc();
      waited++;
    end
    total++; if (led_a[1] !== 1'b1) begin bad++; $display("FAIL arst_wait_led1 got %b want 1", led_a[1]); end
    #3;
    rst_a = 1'b1;
    #1;
    total++; if (led_a !== 3'b000) begin bad++; $display("FAIL arst_led got %b want 000", led_a); end
    total++; if (ch_a !== 2'd0) begin bad++; $display("FAIL arst_channel got %0d want 0", ch_a); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL arst_done got %b want 0", done_a); end
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    cyc();
    cyc(); cyc(); cyc();
    total++; if (dut_a.level_q !== 8'd0) begin bad++; $display("FAIL arst_resume_pre got %0d want 0", dut_a.level_q); end
    cyc();
    total++; if (dut_a.level_q !== 8'd1) begin bad++; $display("FAIL arst_resume_step got %0d want 1", dut_a.level_q); end
    total++; if (ch_a !== 2'd0) begin bad++; $display("FAIL arst_resume_channel got %0d want 0", ch_a); end
  endtask

  task automatic test_disable_reenable();
    int lit = 0;
    int moved = 0;
    restart_a();
    repeat (2560) cyc();
    total++; if (dut_a.level_q !== 8'd130 || ch_a !== 2'd1)
      begin bad++; $display("FAIL dis_pre got level %0d ch%0d want level 130 ch1", dut_a.level_q, ch_a); end
    cyc();
    en_a = 1'b0;
    cyc();
    total++; if (led_a !== 3'b000) begin bad++; $display("FAIL dis_led got %b want 000", led_a); end
    total++; if (ch_a !== 2'd1) begin bad++; $display("FAIL dis_channel got %0d want 1", ch_a); end
    total++; if (dut_a.level_q !== 8'd0) begin bad++; $display("FAIL dis_level got %0d want 0", dut_a.level_q); end
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (led_a != 3'b000) lit++;
      if (ch_a != 2'd1) moved++;
    end
    total++; if (lit != 0 || moved != 0) begin bad++; $display("FAIL dis_hold got lit=%0d moved=%0d want 0 0", lit, moved); end
    en_a = 1'b1;
    cyc();
    cyc(); cyc(); cyc();
    total++; if (dut_a.level_q !== 8'd0) begin bad++; $display("FAIL reen_pre got %0d want 0", dut_a.level_q); end
    cyc();
    total++; if (dut_a.level_q !== 8'd1 || ch_a !== 2'd1)
      begin bad++; $display("FAIL reen_step got level %0d ch%0d want level 1 ch1", dut_a.level_q, ch_a); end
  endtask

  task automatic test_disable_final_tick();
    int pulses = 0;
    int lit = 0;
    int moved = 0;
    int rose = 0;
    restart_a();
    repeat (6119) cyc();
    total++; if (dut_a.level_q !== 8'd1 || ch_a !== 2'd2)
      begin bad++; $display("FAIL fin_pre got level %0d ch%0d want level 1 ch2", dut_a.level_q, ch_a); end
    en_a = 1'b0;
    cyc();
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL fin_done got %b want 0", done_a); end
    total++; if (ch_a !== 2'd2) begin bad++; $display("FAIL fin_channel got %0d want 2", ch_a); end
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (done_a !== 1'b0) pulses++;
      if (led_a != 3'b000) lit++;
      if (ch_a != 2'd2) moved++;
      if (dut_a.level_q != 8'd0) rose++;
    end
    total++; if (pulses != 0 || lit != 0 || moved != 0 || rose != 0)
      begin bad++; $display("FAIL fin_idle got pulses=%0d lit=%0d moved=%0d rose=%0d want all 0", pulses, lit, moved, rose); end
  endtask

  task automatic test_coarse_step();
    int  lv[7] = '{0, 100, 200, 255, 155, 55, 0};
    int  cnt[3] = '{0, 0, 0};
    int  pulses = 0;
    ev_t e;
    exp_q.delete();
    for (int k = 0; k < 7; k++) begin
      e.key = (k == 6) ? 1 : 0;
      e.val = lv[k];
      exp_q.push_back(e);
    end
    rst_b = 1'b0;
    en_b  = 1'b1;
    cyc();
    for (int n = 1; n <= 1792; n++) begin
      cyc();
      for (int i = 0; i < 3; i++) if (led_b[i] === 1'b1) cnt[i]++;
      if (done_b !== 1'b0) pulses++;
      if (n == 1535) begin
        total++; if (ch_b !== 2'd0) begin bad++; $display("FAIL coarse_pre_adv got ch%0d want ch0", ch_b); end
      end
      if (n == 1536) begin
        total++; if (ch_b !== 2'd1) begin bad++; $display("FAIL coarse_adv got ch%0d want ch1", ch_b); end
      end
      if (n % 256 == 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL coarse_window unexpected window at cycle %0d", n);
        end else begin
          e = exp_q.pop_front();
          if (cnt[e.key] !== int'(e.val) || (cnt[0] + cnt[1] + cnt[2] - cnt[e.key]) !== 0) begin
            bad++;
            $display("FAIL coarse_window%0d got active=%0d others=%0d want active=%0d others=0",
                     n / 256 - 1, cnt[e.key], cnt[0] + cnt[1] + cnt[2] - cnt[e.key], e.val);
          end
        end
        cnt = '{0, 0, 0};
      end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL coarse_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_pwm_duty();
    int  cnt[3] = '{0, 0, 0};
    int  stray = 0;
    ev_t e;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      e.key = 0;
      e.val = (k < 4) ? 0 : 64;
      exp_q.push_back(e);
    end
    rst_c = 1'b0;
    en_c  = 1'b1;
    cyc();
    for (int n = 1; n <= 2048; n++) begin
      cyc();
      for (int i = 0; i < 3; i++) if (led_c[i] === 1'b1) cnt[i]++;
      if (done_c !== 1'b0 || ch_c !== 2'd0) stray++;
      if (n % 256 == 0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL duty_window unexpected window at cycle %0d", n);
        end else begin
          e = exp_q.pop_front();
          if (cnt[0] !== int'(e.val) || cnt[1] !== 0 || cnt[2] !== 0) begin
            bad++;
            $display("FAIL duty_window%0d got led0=%0d led1=%0d led2=%0d want led0=%0d led1=0 led2=0",
                     n / 256 - 1, cnt[0], cnt[1], cnt[2], e.val);
          end
        end
        cnt = '{0, 0, 0};
      end
    end
    total++; if (stray != 0) begin bad++; $display("FAIL duty_ch_done got %0d bad cycles want 0", stray); end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0;
    test_reset();
    test_full_chase();
    test_async_reset();
    test_disable_reenable();
    test_disable_final_tick();
    test_coarse_step();
    test_pwm_duty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
